n64_vmux: RTL and testbench
===========================

# n64_vmux

Transmit side of the N64 video bus: serialises pixel words (sync nibble plus 7-bit R, G, B) into the 4-phase nDSYNC/D[6:0] stream that the console's VI drives and that n64_vdemux consumes. It is the stimulus source for bench and loopback testing of the demux path and of the downstream sync/deblur logic. It supports low-res pixel repetition, which the receiver's deblur blanking expects, and 15-bit colour-depth truncation. Input is a valid/ready pixel stream; output is fully registered.

## Interface
Parameters:
- color_width, 7, width of each colour component and of D_o

Ports:
- VCLK  in  1  video clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- pix_valid_i  in  1  pixel word available
- pix_ready_o  out  1  pixel word accepted this cycle when pix_valid_i & pix_ready_o
- pix_sync_i  in  4  {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
- pix_r_i / pix_g_i / pix_b_i  in  color_width each  colour components
- dbl_i  in  1  1 = send each pixel twice (low-res / deblur-able stream)
- n15bit_i  in  1  0 = 15-bit mode, force colour bits [1:0] to 0
- nDSYNC  out  1  low during the sync phase of each 4-cycle group
- D_o  out  color_width  bus data
- underrun_o  out  1  one-cycle pulse: a group was emitted without a pixel

## Operation
- Group = 4 consecutive VCLK cycles, phase 0..3 (2-bit counter, wraps 3→0):
  - phase 0: nDSYNC=0, D_o={3'b000, sync}
  - phase 1: nDSYNC=1, D_o=R
  - phase 2: nDSYNC=1, D_o=G
  - phase 3: nDSYNC=1, D_o=B
- Colour out = n15_r ? comp : {comp[6:2], 2'b00}, applied at each of phases 1–3.
- Current-pixel register cur holds {sync, R, G, B} for the group on the bus.
- rep_pending: set when a new pixel starts a group while dbl_r=1. Cleared when the repeat group starts.
- pix_ready_o = (phase==3) & !rep_pending; combinational from state only.
- At each phase 3→0 transition (next group), the source of the next group is, in priority order:
  - rep_pending=1: cur is re-sent; rep_pending cleared.
  - handshake completes: cur ← input; rep_pending ← dbl_r (using the value after any update below).
  - otherwise (underrun):
    - cur.sync kept, cur RGB ← 0
    - underrun_o=1 during that group's phase 0, but only if started=1
    - no repeat is scheduled
- started: set on the first accepted pixel after reset.
- Mode latch: dbl_r/n15_r ← dbl_i/n15bit_i when an accepted pixel has pix_sync_i[3]=0 and the previously accepted sync[3]=1 (nVSYNC falling edge). The new values apply to that pixel's own group.
- Reset values:
  - nDSYNC=1, D_o=0, underrun_o=0, phase=3
  - cur={4'hF, 0, 0, 0}, rep_pending=0, started=0
  - dbl_r=0, n15_r=1, last accepted nVSYNC=1
- RST mid-group: the group is abandoned and outputs take reset values on the next edge. No partial group resumes.

## Timing
- Accept on edge N: nDSYNC=0 and D_o={000, sync} are visible after edge N. R, G, B follow after edges N+1, N+2, N+3.
- Sustained throughput:
  - dbl_r=0: one pixel per 4 cycles; pix_ready_o high exactly 1 cycle in 4.
  - dbl_r=1: one pixel per 8 cycles; pix_ready_o high 1 cycle in 8, during phase 3 of the repeat group.
- First cycle after RST deasserts: phase=3, so pix_ready_o=1.
- Before the first acceptance, groups carry sync 4'hF and RGB 0, with underrun_o=0.
- pix_valid_i may toggle freely. Input is sampled only when pix_ready_o=1; no data is held off-handshake.
- Simultaneous events:
  - mode latch and acceptance happen on the same edge; the accepted pixel uses the new mode
  - RST overrides an acceptance on the same edge, and the pixel is not consumed

## Test plan
- Reset, then one pixel sync=4'hE, R=7'h55, G=7'h2A, B=7'h7F, n15bit_i=1 → after the accept edge, nDSYNC/D_o = 0/0x0E, 1/0x55, 1/0x2A, 1/0x7F; underrun_o stays 0.
- Continuous stream of 16 pixels, dbl=0 → ready high every 4th cycle; nDSYNC low every 4th cycle; no gaps; loopback through n64_vdemux reproduces all 16 pixels.
- Set dbl_i=1 and n15bit_i=0, then send a pixel with nVSYNC falling, R=7'h7F → groups are emitted in pairs; R reads 0x7C in both groups; ready high every 8th cycle.
- Modes change with no nVSYNC falling edge → output format is unchanged until the next falling edge.
- Withhold valid for one group after the first pixel (sync 4'hB) → group carries sync 0x0B with RGB 0; underrun_o pulses once at phase 0.
- Assert RST at phase 2 → next edge gives nDSYNC=1, D_o=0, pix_ready_o=1; the pending repeat is discarded.

Source files
------------

// File: rtl/n64_vmux.sv
// n64_vmux: serialises sync+RGB pixel words into the 4-phase nDSYNC/D bus stream
module n64_vmux #(
   parameter int color_width = 7
) (
   input  logic                   VCLK,
   input  logic                   RST,
   input  logic                   pix_valid_i,
   output logic                   pix_ready_o,
   input  logic [3:0]             pix_sync_i,
   input  logic [color_width-1:0] pix_r_i,
   input  logic [color_width-1:0] pix_g_i,
   input  logic [color_width-1:0] pix_b_i,
   input  logic                   dbl_i,
   input  logic                   n15bit_i,
   output logic                   nDSYNC,
   output logic [color_width-1:0] D_o,
   output logic                   underrun_o
);
   logic [1:0]             r_phase;
   logic [3:0]             r_sync;
   logic [color_width-1:0] r_r, r_g, r_b;
   logic                   r_rep, r_started, r_dbl, r_n15, r_last_vs;
   logic                   r_ndsync, r_und;
   logic [color_width-1:0] r_d;
   logic                   w_acc, w_latch, w_dbl, w_n15, w_grp, w_rep, w_und;
   logic [1:0]             w_phase;
   logic [3:0]             w_sync;
   logic [color_width-1:0] w_r, w_g, w_b, w_d;

   function automatic logic [color_width-1:0] f_col(input logic [color_width-1:0] c, input logic n15);
      return n15 ? c : {c[color_width-1:2], 2'b00};
   endfunction

   assign pix_ready_o = (r_phase == 2'd3) & ~r_rep;
   assign nDSYNC      = r_ndsync;
   assign D_o         = r_d;
   assign underrun_o  = r_und;

   // next group source selection, mode latch and the bus word for the next phase
   always_comb begin
      w_acc   = pix_valid_i & pix_ready_o;
      w_latch = w_acc & ~pix_sync_i[3] & r_last_vs;
      w_dbl   = w_latch ? dbl_i : r_dbl;
      w_n15   = w_latch ? n15bit_i : r_n15;
      w_grp   = r_phase == 2'd3;
      w_phase = r_phase + 2'd1;
      w_sync  = r_sync;
      w_r     = r_r;
      w_g     = r_g;
      w_b     = r_b;
      w_rep   = r_rep;
      if (w_grp) begin
         if (r_rep) begin
            w_rep = 1'b0;
         end else if (w_acc) begin
            w_sync = pix_sync_i;
            w_r    = pix_r_i;
            w_g    = pix_g_i;
            w_b    = pix_b_i;
            w_rep  = w_dbl;
         end else begin
            w_r   = '0;
            w_g   = '0;
            w_b   = '0;
            w_rep = 1'b0;
         end
      end
      w_und = w_grp & ~r_rep & ~w_acc & r_started;
      w_d   = (w_phase == 2'd0) ? {{(color_width-4){1'b0}}, w_sync} :
              (w_phase == 2'd1) ? f_col(w_r, w_n15) :
              (w_phase == 2'd2) ? f_col(w_g, w_n15) : f_col(w_b, w_n15);
   end

   // state and fully registered bus outputs
   always_ff @(posedge VCLK) begin
      if (RST) begin
         r_phase   <= 2'd3;
         r_sync    <= 4'hF;
         r_r       <= '0;
         r_g       <= '0;
         r_b       <= '0;
         r_rep     <= 1'b0;
         r_started <= 1'b0;
         r_dbl     <= 1'b0;
         r_n15     <= 1'b1;
         r_last_vs <= 1'b1;
         r_ndsync  <= 1'b1;
         r_d       <= '0;
         r_und     <= 1'b0;
      end else begin
         r_phase   <= w_phase;
         r_sync    <= w_sync;
         r_r       <= w_r;
         r_g       <= w_g;
         r_b       <= w_b;
         r_rep     <= w_rep;
         r_started <= r_started | w_acc;
         r_dbl     <= w_dbl;
         r_n15     <= w_n15;
         r_last_vs <= w_acc ? pix_sync_i[3] : r_last_vs;
         r_ndsync  <= w_phase != 2'd0;
         r_d       <= w_d;
         r_und     <= w_und;
      end
   end
endmodule

// File: tb/tb_n64_vmux.sv
// tb_n64_vmux: directed-vector bench for the N64 video bus serialiser
module tb_n64_vmux;
   logic       VCLK = 1'b0;
   logic       RST = 1'b1;
   logic       pix_valid_i = 1'b0;
   logic       pix_ready_o;
   logic [3:0] pix_sync_i = 4'h0;
   logic [6:0] pix_r_i = '0, pix_g_i = '0, pix_b_i = '0;
   logic       dbl_i = 1'b0;
   logic       n15bit_i = 1'b1;
   logic       nDSYNC;
   logic [6:0] D_o;
   logic       underrun_o;
   int         n_chk = 0;
   int         n_fail = 0;

   n64_vmux dut (
      .VCLK(VCLK), .RST(RST), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .pix_sync_i(pix_sync_i), .pix_r_i(pix_r_i), .pix_g_i(pix_g_i), .pix_b_i(pix_b_i),
      .dbl_i(dbl_i), .n15bit_i(n15bit_i), .nDSYNC(nDSYNC), .D_o(D_o), .underrun_o(underrun_o)
   );

   always #5 VCLK = ~VCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge VCLK);
      #1;
   endtask

   function automatic logic [9:0] bus();
      return {nDSYNC, D_o, underrun_o, pix_ready_o};
   endfunction

   // checks the group whose phase 0 is on the bus now; ends at its phase 3
   task automatic expect_grp(input string tag, input logic [3:0] s, input logic [6:0] r, g, b,
                             input logic u, input logic rdy3);
      chk({tag, "_p0"}, bus(), {1'b0, 3'b000, s, u, 1'b0});
      step();
      chk({tag, "_r"}, bus(), {1'b1, r, 1'b0, 1'b0});
      step();
      chk({tag, "_g"}, bus(), {1'b1, g, 1'b0, 1'b0});
      step();
      chk({tag, "_b"}, bus(), {1'b1, b, 1'b0, rdy3});
   endtask

   task automatic send(input logic [3:0] s, input logic [6:0] r, g, b);
      int n = 0;
      while (!pix_ready_o && n < 16) begin
         step();
         n++;
      end
      chk("rdy_wait", pix_ready_o, 1'b1);
      pix_valid_i = 1'b1;
      pix_sync_i = s;
      pix_r_i = r;
      pix_g_i = g;
      pix_b_i = b;
      step();
      pix_valid_i = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("reset", bus(), {1'b1, 7'h00, 1'b0, 1'b1});
      RST = 1'b0;
      chk("first_ready", pix_ready_o, 1'b1);
      send(4'hE, 7'h55, 7'h2A, 7'h7F);
      expect_grp("pix1", 4'hE, 7'h55, 7'h2A, 7'h7F, 1'b0, 1'b1);
      step();
      expect_grp("und_e", 4'hE, 7'h00, 7'h00, 7'h00, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         logic [6:0] r, g, b;
         r = 7'(i * 5 + 1);
         g = 7'(7'h40 ^ i);
         b = 7'(7'h7F - i * 3);
         send({1'b1, 3'(i)}, r, g, b);
         expect_grp("stream", {1'b1, 3'(i)}, r, g, b, 1'b0, 1'b1);
      end
      dbl_i = 1'b1;
      n15bit_i = 1'b0;
      send(4'h9, 7'h7F, 7'h13, 7'h0E);
      expect_grp("nolatch", 4'h9, 7'h7F, 7'h13, 7'h0E, 1'b0, 1'b1);
      send(4'h7, 7'h7F, 7'h2B, 7'h41);
      expect_grp("dbl_a", 4'h7, 7'h7C, 7'h28, 7'h40, 1'b0, 1'b0);
      pix_valid_i = 1'b1;
      pix_sync_i = 4'h1;
      pix_r_i = 7'h11;
      step();
      pix_valid_i = 1'b0;
      expect_grp("dbl_b", 4'h7, 7'h7C, 7'h28, 7'h40, 1'b0, 1'b1);
      dbl_i = 1'b0;
      n15bit_i = 1'b1;
      send(4'h5, 7'h7F, 7'h13, 7'h0E);
      expect_grp("keep_a", 4'h5, 7'h7C, 7'h10, 7'h0C, 1'b0, 1'b0);
      step();
      expect_grp("keep_b", 4'h5, 7'h7C, 7'h10, 7'h0C, 1'b0, 1'b1);
      send(4'hD, 7'h0A, 7'h0B, 7'h0F);
      expect_grp("vshi_a", 4'hD, 7'h08, 7'h08, 7'h0C, 1'b0, 1'b0);
      step();
      expect_grp("vshi_b", 4'hD, 7'h08, 7'h08, 7'h0C, 1'b0, 1'b1);
      send(4'h3, 7'h0A, 7'h0B, 7'h0F);
      expect_grp("relatch", 4'h3, 7'h0A, 7'h0B, 7'h0F, 1'b0, 1'b1);
      send(4'hB, 7'h11, 7'h22, 7'h33);
      expect_grp("pix_b", 4'hB, 7'h11, 7'h22, 7'h33, 1'b0, 1'b1);
      step();
      expect_grp("und_b", 4'hB, 7'h00, 7'h00, 7'h00, 1'b1, 1'b1);
      dbl_i = 1'b1;
      send(4'h2, 7'h44, 7'h45, 7'h46);
      chk("rst_p0", bus(), {1'b0, 7'h02, 1'b0, 1'b0});
      step();
      step();
      chk("rst_p2", bus(), {1'b1, 7'h45, 1'b0, 1'b0});
      RST = 1'b1;
      step();
      chk("rst_mid", bus(), {1'b1, 7'h00, 1'b0, 1'b1});
      RST = 1'b0;
      dbl_i = 1'b0;
      step();
      expect_grp("post_rst", 4'hF, 7'h00, 7'h00, 7'h00, 1'b0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
